// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a MEM-stage client (master) and data_mem_ctrl (slave).
// Latency: none, wires only.
// Backpressure: req_ready from the slave, resp_ready from the master.
interface data_mem_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  init_done;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, init_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, init_done
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with a power-up clear sweep and a request/response handshake.
// Latency: access LATENCY edges after acceptance, response valid from that cycle.
// Backpressure: one request in flight; response is held while resp_ready is low.
module data_mem_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    LATENCY    = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic            clock,
    input  logic            reset_n,
    data_mem_ctrl_if.slave  bus
);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  init_done_q, init_done_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        init_done_d = init_done_q;
        mem_we      = 1'b0;
        mem_waddr   = addr_q;
        mem_wdata   = wdata_q;

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                mem_wdata = INIT_VALUE;
                sweep_d   = sweep_q + ADDR_WIDTH'(1);
                if (sweep_q == '1) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = LAT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Writes echo their data so the client sees a uniform response.
                    if (wr_q) begin
                        mem_we  = 1'b1;
                        rdata_d = wdata_q;
                    end else begin
                        rdata_d = mem_q[addr_q];
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Reset wins over a completing write; the sweep rewrites the array anyway.
        if (!reset_n) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            init_done_q <= init_done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.init_done  = init_done_q;
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised single-port data memory with a request/response handshake, programmable access latency, and a hardware initialisation sweep after reset. It replaces the fixed 8-bit × 256 data memory in the datapath's MEM stage. Because the response is valid/ready based, the pipeline can stall on memory accesses, and memory contents come from a deterministic power-up clear instead of hard-coded words.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 8, address width; DEPTH = 2^ADDR_WIDTH words
- LATENCY, 2, cycles spent in WAIT per access; legal range is 1 to 15
- INIT_VALUE, 0, value written to every word during the init sweep

Ports:
- clock  in  1  single clock; all state changes on its rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  DATA_WIDTH  read data; for a write, echoes the written data
- init_done  out  1  init sweep finished

## Operation
- States: INIT, IDLE, WAIT, RESP.
- Reset: reset_n low at a rising edge gives state=INIT, sweep address=0, req_ready=0, resp_valid=0, resp_rdata=0, init_done=0.
  - Any pending request is dropped and no response is produced for it.
- INIT:
  - Writes INIT_VALUE to the sweep address on each edge, then increments the address.
  - After writing address DEPTH-1, moves to IDLE and sets init_done=1.
  - init_done stays 1 until the next reset.
- IDLE:
  - req_ready=1.
  - When req_valid&&req_ready at an edge: latch req_write, req_addr and req_wdata; load the latency counter with LATENCY-1; go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter not zero: decrement it.
  - Counter zero: perform the access at this edge, then go to RESP.
    - Write: word[addr] <= wdata and resp_rdata <= wdata.
    - Read: resp_rdata <= word[addr].
- RESP:
  - resp_valid=1.
  - resp_rdata holds stable while resp_ready=0.
  - When resp_valid&&resp_ready at an edge: resp_valid <= 0 and go to IDLE.
- Only the latched request fields are used after acceptance; req_* may change freely afterwards.
- req_valid while req_ready=0 is ignored and has no side effects.
- The address space is fully decoded. There is no out-of-range case and no wrap beyond DEPTH-1.
- Read-after-write to the same address returns the new data, since accesses are strictly serialised.

## Timing
- Init duration: DEPTH edges with reset_n=1. init_done and req_ready rise together after edge DEPTH.
- Acceptance at edge k:
  - Access is performed at edge k+LATENCY.
  - resp_valid is high from cycle k+LATENCY.
- Minimum turnaround with resp_ready tied high: one request per LATENCY+2 cycles.
- Backpressure: each cycle resp_ready is low adds one cycle in RESP. No request is accepted in that time.
- reset_n low in any state takes priority over every transition, including completion of a write in WAIT.
  - That write is not performed.
  - The init sweep overwrites the whole array regardless.
- resp_rdata is unchanged between responses. It is written only at access edges and at reset.

## Test plan
- Reset, then release: init_done=0 and req_ready=0 for exactly 256 cycles, both 1 afterwards. Then read addr 100 → resp_rdata=0x00.
- Write 150 to addr 100, then read addr 100 with LATENCY=2: write response echoes 150; read response resp_rdata=150; resp_valid rises 2 cycles after each acceptance.
- Read addr 100 with resp_ready held low for 5 cycles:
  - resp_valid stays 1 and resp_rdata stays 150 throughout.
  - req_ready stays 0, and a req_valid pulse in that window is ignored.
  - After resp_ready=1, the block returns to IDLE on the next edge.
- Write 0x55 to addr 7, then assert reset_n=0 the cycle after acceptance:
  - No resp_valid occurs.
  - After the re-init sweep, reading addr 7 returns 0x00.
- Instance with DATA_WIDTH=16, ADDR_WIDTH=4, LATENCY=1, INIT_VALUE=16'hA5A5:
  - init lasts 16 cycles.
  - Write 16'hBEEF to addr 15; read addr 15 → 16'hBEEF; read addr 0 → 16'hA5A5.
  - resp_valid rises 1 cycle after acceptance.
- Back-to-back reads to addrs 100..103 after writes of 150, 7, 151, 9 with resp_ready tied high: responses arrive in order with those values, one every LATENCY+2 cycles.
